// File: rtl/peak_frame_scheduler_if.sv
// Peak-in, PISO and FIFO-write signals of the peak frame scheduler.
// The scheduler takes the slave side; the surrounding datapath or a bench takes the master side.
interface peak_frame_scheduler_if #(
    parameter int SLOTS = 16,
    parameter int DW    = 25,
    parameter int FW    = 9
);
    logic                  peak_valid;
    logic [DW-1:0]         peak_data;
    logic                  piso_load;
    logic [SLOTS*DW-1:0]   piso_data;
    logic                  piso_active;
    logic [FW-1:0]         piso_serial;
    logic                  fifo_full;
    logic                  fifo_winc;
    logic [FW-1:0]         fifo_wdata;

    modport master (
        output peak_valid, peak_data, piso_active, piso_serial, fifo_full,
        input  piso_load, piso_data, fifo_winc, fifo_wdata
    );

    modport slave (
        input  peak_valid, peak_data, piso_active, piso_serial, fifo_full,
        output piso_load, piso_data, fifo_winc, fifo_wdata
    );
endinterface

// File: rtl/peak_frame_scheduler.sv
// Gathers SLOTS peak words into a frame buffer. Once the PISO is idle, it emits a sync
// header, loads the PISO and passes the serialized frequencies through to the FIFO.
module peak_frame_scheduler #(
    parameter int            SLOTS     = 16,
    parameter int            DW        = 25,
    parameter int            FW        = 9,
    parameter logic [FW-1:0] SYNC_WORD = 9'h1FF,
    parameter int            WATCHDOG  = 64,
    parameter int            CW        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    peak_frame_scheduler_if.slave bus,
    output logic [CW-1:0]         frames_sent,
    output logic [CW-1:0]         drop_count,
    output logic                  overflow,
    output logic                  wd_error
);
    localparam int IW  = $clog2(SLOTS);
    localparam int WDW = $clog2(WATCHDOG + 1);

    typedef enum logic [1:0] {IDLE, HEADER, LOAD, STREAM} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       buf_q [SLOTS];
    logic [DW-1:0]       buf_d [SLOTS];
    logic [IW-1:0]       wr_idx_q, wr_idx_d;
    logic                buf_full_q, buf_full_d;
    logic [SLOTS*DW-1:0] piso_data_q, piso_data_d;
    logic                seen_q, seen_d;
    logic [WDW-1:0]      wd_cnt_q, wd_cnt_d;
    logic [CW-1:0]       frames_q, frames_d;
    logic [CW-1:0]       drop_q, drop_d;
    logic                overflow_q, overflow_d;
    logic                wd_error_q, wd_error_d;

    logic                cap_full;
    logic [IW-1:0]       cap_idx;
    logic [DW-1:0]       peak_word;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_idx_q    <= '0;
            buf_full_q  <= 1'b0;
            piso_data_q <= '0;
            seen_q      <= 1'b0;
            wd_cnt_q    <= '0;
            frames_q    <= '0;
            drop_q      <= '0;
            overflow_q  <= 1'b0;
            wd_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            buf_full_q  <= buf_full_d;
            piso_data_q <= piso_data_d;
            seen_q      <= seen_d;
            wd_cnt_q    <= wd_cnt_d;
            frames_q    <= frames_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
            wd_error_q  <= wd_error_d;
        end
    end

    // NOTE: the frame buffer is deliberately left without reset. A slot is read only
    // after all SLOTS entries have been rewritten, so resetting it would add no value.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Capture path. The LOAD cycle already presents an empty buffer to the incoming peak.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        buf_d      = buf_q;
        wr_idx_d   = wr_idx_q;
        buf_full_d = buf_full_q;
        drop_d     = drop_q;
        cap_full   = buf_full_q;
        cap_idx    = wr_idx_q;
        if (state_q == LOAD) begin
            cap_full   = 1'b0;
            cap_idx    = '0;
            buf_full_d = 1'b0;
            wr_idx_d   = '0;
        end
        peak_word = bus.peak_data;
        if (peak_word[DW-1 -: FW] == SYNC_WORD) peak_word[DW-1 -: FW] = SYNC_WORD - 1'b1;
        if (bus.peak_valid) begin
            if (!cap_full) begin
                buf_d[cap_idx] = peak_word;
                wr_idx_d       = cap_idx + 1'b1;
                if (cap_idx == IW'(SLOTS - 1)) begin
                    buf_full_d = 1'b1;
                    wr_idx_d   = '0;
                end
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    // Next-state logic and frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        piso_data_d = piso_data_q;
        seen_d      = seen_q;
        wd_cnt_d    = wd_cnt_q;
        frames_d    = frames_q;
        overflow_d  = overflow_q;
        wd_error_d  = wd_error_q;
        case (state_q)
            IDLE: begin
                if (buf_full_q && !bus.piso_active) state_d = HEADER;
            end
            HEADER: begin
                for (int i = 0; i < SLOTS; i++) piso_data_d[i*DW +: DW] = buf_q[i];
                if (bus.fifo_full) overflow_d = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                seen_d   = 1'b0;
                wd_cnt_d = '0;
                state_d  = STREAM;
            end
            STREAM: begin
                if (!seen_q) wd_cnt_d = wd_cnt_q + 1'b1;
                if (bus.piso_active) begin
                    seen_d = 1'b1;
                    if (bus.fifo_full) overflow_d = 1'b1;
                end else if (seen_q) begin
                    frames_d = frames_q + 1'b1;
                    state_d  = IDLE;
                end else if (wd_cnt_q == WDW'(WATCHDOG - 1)) begin
                    wd_error_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The FIFO port is driven combinationally, so a serial word reaches the FIFO in its own cycle.
    always_comb begin
        bus.piso_load  = (state_q == LOAD);
        bus.fifo_winc  = 1'b0;
        bus.fifo_wdata = '0;
        if (state_q == HEADER && !bus.fifo_full) begin
            bus.fifo_winc  = 1'b1;
            bus.fifo_wdata = SYNC_WORD;
        end else if (state_q == STREAM && bus.piso_active && !bus.fifo_full) begin
            bus.fifo_winc  = 1'b1;
            bus.fifo_wdata = bus.piso_serial;
        end
    end

    assign bus.piso_data = piso_data_q;
    assign frames_sent   = frames_q;
    assign drop_count    = drop_q;
    assign overflow      = overflow_q;
    assign wd_error      = wd_error_q;
endmodule

// File: tb/tb_peak_frame_scheduler.sv
// Directed bench for peak_frame_scheduler: a small PISO model streams each loaded frame,
// and a FIFO monitor records each write for comparison against hand-computed sequences.
module tb_peak_frame_scheduler;
    localparam int SLOTS = 16;
    localparam int DW    = 25;
    localparam int FW    = 9;
    localparam logic [FW-1:0] SYNC = 9'h1FF;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] frames_sent, drop_count;
    logic overflow, wd_error;

    always #10 clk = ~clk;

    peak_frame_scheduler_if #(.SLOTS(SLOTS), .DW(DW), .FW(FW)) bus ();

    peak_frame_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .frames_sent(frames_sent),
        .drop_count (drop_count),
        .overflow   (overflow),
        .wd_error   (wd_error)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO monitor
    logic [FW-1:0] wq[$];
    int load_cnt = 0, hdr_cyc = 0, load_cyc = 0, winc_full = 0, bad_wdata = 0;
    initial forever begin
        @(negedge clk);
        if (bus.fifo_winc) begin
            wq.push_back(bus.fifo_wdata);
            if (bus.fifo_wdata == SYNC) hdr_cyc = cyc;
            if (bus.fifo_full) winc_full++;
        end else if (bus.fifo_wdata !== '0) begin
            bad_wdata++;
        end
        if (bus.piso_load) begin
            load_cnt++;
            load_cyc = cyc;
        end
    end

    // PISO model: after a load pulse, stay active for SLOTS cycles and shift out slot frequencies
    logic piso_en;
    logic [SLOTS*DW-1:0] snap;
    int fall_cyc = 0;
    initial begin
        bus.piso_active = 1'b0;
        bus.piso_serial = '0;
        forever begin
            @(negedge clk);
            if (bus.piso_load && piso_en) begin
                snap = bus.piso_data;
                for (int i = 0; i < SLOTS; i++) begin
                    @(posedge clk); #1;
                    bus.piso_active = 1'b1;
                    bus.piso_serial = snap[i*DW + DW - FW +: FW];
                end
                @(posedge clk); #1;
                bus.piso_active = 1'b0;
                bus.piso_serial = '0;
                fall_cyc = cyc;
            end
        end
    end

    int last_peak_cyc = 0;

    task automatic send_peaks(input int n, input int base, input int gap, input int sync_slot);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.peak_valid = 1'b1;
            bus.peak_data  = {((i == sync_slot) ? SYNC : FW'(base + i)), 16'(16'h0A00 | i)};
            last_peak_cyc  = cyc;
            if (gap > 1) begin
                @(posedge clk); #1;
                bus.peak_valid = 1'b0;
                repeat (gap - 2) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        bus.peak_valid = 1'b0;
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.piso_load) ok = 1'b1;
        end
    endtask

    task automatic wait_header(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (bus.fifo_winc && bus.fifo_wdata == SYNC) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (bus.piso_load !== 1'b0) $display("FAIL reset_load got %b want 0", bus.piso_load); else passed++;
        total++; if (bus.fifo_winc !== 1'b0) $display("FAIL reset_winc got %b want 0", bus.fifo_winc); else passed++;
        total++; if (bus.fifo_wdata !== '0) $display("FAIL reset_wdata got %h want 0", bus.fifo_wdata); else passed++;
        total++; if (bus.piso_data !== '0) $display("FAIL reset_piso_data got %h want 0", bus.piso_data); else passed++;
        total++; if (frames_sent !== 16'd0) $display("FAIL reset_frames got %0d want 0", frames_sent); else passed++;
        total++; if (drop_count !== 16'd0) $display("FAIL reset_drops got %0d want 0", drop_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
        total++; if (wd_error !== 1'b0) $display("FAIL reset_wd_error got %b want 0", wd_error); else passed++;
    endtask

    task automatic test_basic();
        int mark, lc;
        logic [FW-1:0] exp;
        mark = wq.size();
        lc   = load_cnt;
        send_peaks(16, 1, 200, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        total++; if (wq.size() - mark != 17) $display("FAIL basic_words got %0d want 17", wq.size() - mark); else passed++;
        for (int k = 0; k < 17; k++) begin
            exp = (k == 0) ? SYNC : FW'(k);
            total++;
            if (mark + k >= wq.size() || wq[mark + k] !== exp)
                $display("FAIL basic_word%0d got %h want %h", k, (mark + k < wq.size()) ? wq[mark + k] : 'x, exp);
            else passed++;
        end
        total++; if (load_cnt - lc != 1) $display("FAIL basic_loads got %0d want 1", load_cnt - lc); else passed++;
        total++; if (hdr_cyc - last_peak_cyc != 2) $display("FAIL basic_hdr_latency got %0d want 2", hdr_cyc - last_peak_cyc); else passed++;
        total++; if (load_cyc - hdr_cyc != 1) $display("FAIL basic_load_latency got %0d want 1", load_cyc - hdr_cyc); else passed++;
        total++; if (frames_sent !== 16'd1) $display("FAIL basic_frames got %0d want 1", frames_sent); else passed++;
        total++; if (drop_count !== 16'd0) $display("FAIL basic_drops got %0d want 0", drop_count); else passed++;
    endtask

    task automatic test_clamp();
        int mark, n_sync;
        logic [FW-1:0] exp;
        logic [DW-1:0] exp_slot;
        mark = wq.size();
        send_peaks(16, 100, 0, 3);
        repeat (40) @(posedge clk);
        @(negedge clk);
        exp_slot = {9'd510, 16'h0A03};
        total++; if (snap[3*DW +: DW] !== exp_slot) $display("FAIL clamp_slot3 got %h want %h", snap[3*DW +: DW], exp_slot); else passed++;
        total++; if (wq.size() - mark != 17) $display("FAIL clamp_words got %0d want 17", wq.size() - mark); else passed++;
        n_sync = 0;
        for (int k = 0; k < 17; k++) begin
            exp = (k == 0) ? SYNC : ((k == 4) ? 9'd510 : FW'(100 + k - 1));
            total++;
            if (mark + k >= wq.size() || wq[mark + k] !== exp)
                $display("FAIL clamp_word%0d got %h want %h", k, (mark + k < wq.size()) ? wq[mark + k] : 'x, exp);
            else passed++;
            if (mark + k < wq.size() && wq[mark + k] == SYNC) n_sync++;
        end
        total++; if (n_sync != 1) $display("FAIL clamp_sync_count got %0d want 1", n_sync); else passed++;
        total++; if (frames_sent !== 16'd2) $display("FAIL clamp_frames got %0d want 2", frames_sent); else passed++;
    endtask

    task automatic test_back_to_back();
        int mark;
        bit ok;
        logic [15:0] d0, f0;
        logic [FW-1:0] exp;
        mark = wq.size();
        d0 = drop_count;
        f0 = frames_sent;
        send_peaks(16, 20, 0, -1);
        wait_header(ok);
        total++; if (!ok) $display("FAIL b2b_header_timeout got none want header"); else passed++;
        // The first of the 20 peaks lands in the LOAD cycle and becomes slot 0 of the next frame
        send_peaks(20, 40, 0, -1);
        total++; if (hdr_cyc - fall_cyc != 2) $display("FAIL b2b_hdr_after_fall got %0d want 2", hdr_cyc - fall_cyc); else passed++;
        repeat (60) @(posedge clk);
        @(negedge clk);
        total++; if (drop_count - d0 != 16'd4) $display("FAIL b2b_drops got %0d want 4", drop_count - d0); else passed++;
        total++; if (frames_sent - f0 != 16'd2) $display("FAIL b2b_frames got %0d want 2", frames_sent - f0); else passed++;
        total++; if (wq.size() - mark != 34) $display("FAIL b2b_words got %0d want 34", wq.size() - mark); else passed++;
        for (int k = 0; k < 34; k++) begin
            if (k == 0 || k == 17) exp = SYNC;
            else if (k < 17)      exp = FW'(20 + k - 1);
            else                  exp = FW'(40 + k - 18);
            total++;
            if (mark + k >= wq.size() || wq[mark + k] !== exp)
                $display("FAIL b2b_word%0d got %h want %h", k, (mark + k < wq.size()) ? wq[mark + k] : 'x, exp);
            else passed++;
        end
    endtask

    task automatic test_fifo_full();
        int mark, wf0;
        bit ok;
        logic [15:0] f0;
        logic [FW-1:0] exp;
        mark = wq.size();
        f0   = frames_sent;
        wf0  = winc_full;
        total++; if (overflow !== 1'b0) $display("FAIL full_overflow_pre got %b want 0", overflow); else passed++;
        send_peaks(16, 60, 0, -1);
        wait_load(ok);
        total++; if (!ok) $display("FAIL full_load_timeout got none want load"); else passed++;
        repeat (6) @(posedge clk);
        #1 bus.fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.fifo_full = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        total++; if (wq.size() - mark != 12) $display("FAIL full_words got %0d want 12", wq.size() - mark); else passed++;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)     exp = SYNC;
            else if (k < 6) exp = FW'(60 + k - 1);
            else            exp = FW'(70 + k - 6);
            total++;
            if (mark + k >= wq.size() || wq[mark + k] !== exp)
                $display("FAIL full_word%0d got %h want %h", k, (mark + k < wq.size()) ? wq[mark + k] : 'x, exp);
            else passed++;
        end
        total++; if (winc_full != wf0) $display("FAIL full_winc_while_full got %0d want 0", winc_full - wf0); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL full_overflow got %b want 1", overflow); else passed++;
        total++; if (frames_sent - f0 != 16'd1) $display("FAIL full_frames got %0d want 1", frames_sent - f0); else passed++;
        total++; if (bad_wdata != 0) $display("FAIL idle_wdata_nonzero got %0d want 0", bad_wdata); else passed++;
    endtask

    task automatic test_watchdog();
        int mark;
        bit ok;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        piso_en = 1'b0;
        mark = wq.size();
        send_peaks(16, 80, 0, -1);
        wait_load(ok);
        total++; if (!ok) $display("FAIL wd_load_timeout got none want load"); else passed++;
        repeat (64) @(negedge clk);
        total++; if (wd_error !== 1'b0) $display("FAIL wd_early got %b want 0", wd_error); else passed++;
        @(negedge clk);
        total++; if (wd_error !== 1'b1) $display("FAIL wd_expire got %b want 1", wd_error); else passed++;
        total++; if (frames_sent !== 16'd0) $display("FAIL wd_frames got %0d want 0", frames_sent); else passed++;
        total++; if (wq.size() - mark != 1) $display("FAIL wd_words got %0d want 1", wq.size() - mark); else passed++;
        piso_en = 1'b1;
        send_peaks(16, 150, 0, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        total++; if (frames_sent !== 16'd1) $display("FAIL wd_recover_frames got %0d want 1", frames_sent); else passed++;
        total++; if (wq[wq.size() - 1] !== FW'(165)) $display("FAIL wd_recover_last got %h want %h", wq[wq.size() - 1], FW'(165)); else passed++;
        total++; if (wd_error !== 1'b1) $display("FAIL wd_sticky got %b want 1", wd_error); else passed++;
    endtask

    task automatic test_reset_mid_stream();
        int mark;
        bit ok;
        logic [FW-1:0] exp;
        send_peaks(16, 90, 0, -1);
        wait_load(ok);
        total++; if (!ok) $display("FAIL rst_load_timeout got none want load"); else passed++;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (bus.piso_load !== 1'b0) $display("FAIL rst_mid_load got %b want 0", bus.piso_load); else passed++;
        total++; if (bus.fifo_winc !== 1'b0) $display("FAIL rst_mid_winc got %b want 0", bus.fifo_winc); else passed++;
        total++; if (bus.fifo_wdata !== '0) $display("FAIL rst_mid_wdata got %h want 0", bus.fifo_wdata); else passed++;
        total++; if (bus.piso_data !== '0) $display("FAIL rst_mid_piso_data got %h want 0", bus.piso_data); else passed++;
        total++; if (frames_sent !== 16'd0) $display("FAIL rst_mid_frames got %0d want 0", frames_sent); else passed++;
        total++; if (drop_count !== 16'd0) $display("FAIL rst_mid_drops got %0d want 0", drop_count); else passed++;
        total++; if (overflow !== 1'b0 || wd_error !== 1'b0)
            $display("FAIL rst_mid_sticky got %b%b want 00", overflow, wd_error); else passed++;
        mark = wq.size();
        repeat (20) @(negedge clk);
        total++; if (wq.size() != mark) $display("FAIL rst_mid_abandon got %0d want 0", wq.size() - mark); else passed++;
        send_peaks(16, 120, 0, -1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        total++; if (frames_sent !== 16'd1) $display("FAIL rst_fresh_frames got %0d want 1", frames_sent); else passed++;
        total++; if (wq.size() - mark != 17) $display("FAIL rst_fresh_words got %0d want 17", wq.size() - mark); else passed++;
        for (int k = 0; k < 17; k++) begin
            exp = (k == 0) ? SYNC : FW'(120 + k - 1);
            total++;
            if (mark + k >= wq.size() || wq[mark + k] !== exp)
                $display("FAIL rst_fresh_word%0d got %h want %h", k, (mark + k < wq.size()) ? wq[mark + k] : 'x, exp);
            else passed++;
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.peak_valid = 1'b0;
        bus.peak_data  = '0;
        bus.fifo_full  = 1'b0;
        piso_en        = 1'b1;
        test_reset();
        test_basic();
        test_clamp();
        test_back_to_back();
        test_fifo_full();
        test_watchdog();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #(20 * 50000);
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
